// File: rtl/perceptron_trainer_if.sv
// rtl/perceptron_trainer_if.sv - sample stream (valid/ready, packed inputs, bipolar target)
interface perceptron_trainer_if #(
  parameter int NUM_IN = 2,
  parameter int XW     = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [NUM_IN*XW-1:0] s_x;
  logic                 s_t;

  modport master (output s_valid, output s_x, output s_t, input s_ready);
  modport slave  (input s_valid, input s_x, input s_t, output s_ready);
endinterface

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - single-neuron perceptron trainer, sequential MAC, epoch controller
// Optional macro PERCEPTRON_WEIGHT_SAT_EN: weight/bias updates saturate instead of wrapping.
module perceptron_trainer #(
  parameter int NUM_IN    = 2,
  parameter int XW        = 8,
  parameter int WW        = 16,
  parameter int LR_SHIFT  = 0,
  parameter int CNT_W     = 20,
  parameter int EP_W      = 12,
  parameter int MAX_EPOCH = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_samples,
  perceptron_trainer_if.slave  s_if,
  output logic [NUM_IN*WW-1:0] w,
  output logic [WW-1:0]        b,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [EP_W-1:0]      epoch_cnt,
  output logic [CNT_W-1:0]     err_cnt
);
  localparam int ACC_W = XW + WW + $clog2(NUM_IN + 1);
  localparam int SUM_W = WW + XW + LR_SHIFT + 1;
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic signed [SUM_W-1:0] B_STEP = SUM_W'(1) <<< LR_SHIFT;
`ifdef PERCEPTRON_WEIGHT_SAT_EN
  localparam logic signed [SUM_W-1:0] W_MAX = {{(SUM_W-WW+1){1'b0}}, {(WW-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] W_MIN = {{(SUM_W-WW+1){1'b1}}, {(WW-1){1'b0}}};
`endif

  typedef enum logic [2:0] {IDLE, WAIT_S, MAC, EVAL, UPD, EPOCH_END, FIN} state_t;

  state_t                  r_state, w_next_state;
  logic signed [WW-1:0]    r_w [NUM_IN];
  logic signed [WW-1:0]    r_b;
  logic signed [WW-1:0]    w_w_upd [NUM_IN];
  logic signed [WW-1:0]    w_b_upd;
  logic signed [SUM_W-1:0] w_step [NUM_IN];
  logic [NUM_IN*XW-1:0]    r_x;
  logic                    r_t;
  logic signed [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_n, r_scnt, r_err;
  logic [EP_W-1:0]         r_epoch, w_epoch_inc;
  logic                    r_busy, r_done, r_conv;
  logic signed [XW-1:0]    w_x_cur;
  logic signed [XW+WW-1:0] w_prod;
  logic                    w_mismatch, w_last, w_stop;

  function automatic logic signed [WW-1:0] reduce_w(input logic signed [SUM_W-1:0] v);
`ifdef PERCEPTRON_WEIGHT_SAT_EN
    if (v > W_MAX) return W_MAX[WW-1:0];
    if (v < W_MIN) return W_MIN[WW-1:0];
    return v[WW-1:0];
`else
    return v[WW-1:0];
`endif
  endfunction

  assign w_x_cur     = r_x[r_idx*XW +: XW];
  assign w_prod      = w_x_cur * r_w[r_idx];
  // acc >= 0 predicts +1, so a mismatch is exactly sign bit equal to target bit
  assign w_mismatch  = (r_acc[ACC_W-1] == r_t);
  assign w_last      = (r_scnt == r_n);
  assign w_epoch_inc = r_epoch + EP_W'(1);
  assign w_stop      = (r_err == '0) || (w_epoch_inc == EP_W'(MAX_EPOCH));

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      w_step[i]  = SUM_W'($signed(r_x[i*XW +: XW])) <<< LR_SHIFT;
      w_w_upd[i] = reduce_w(r_t ? SUM_W'(r_w[i]) + w_step[i] : SUM_W'(r_w[i]) - w_step[i]);
    end
    w_b_upd = reduce_w(r_t ? SUM_W'(r_b) + B_STEP : SUM_W'(r_b) - B_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (start) w_next_state = (n_samples == '0) ? FIN : WAIT_S;
      WAIT_S:    if (s_if.s_valid) w_next_state = MAC;
      MAC:       if (r_idx == IDX_W'(NUM_IN - 1)) w_next_state = EVAL;
      EVAL:      w_next_state = w_mismatch ? UPD : (w_last ? EPOCH_END : WAIT_S);
      UPD:       w_next_state = w_last ? EPOCH_END : WAIT_S;
      EPOCH_END: w_next_state = w_stop ? FIN : WAIT_S;
      FIN:       w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) r_w[i] <= '0;
      r_b     <= '0;
      r_x     <= '0;
      r_t     <= 1'b0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_n     <= '0;
      r_scnt  <= '0;
      r_err   <= '0;
      r_epoch <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_conv  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          for (int i = 0; i < NUM_IN; i++) r_w[i] <= '0;
          r_b     <= '0;
          r_epoch <= '0;
          r_err   <= '0;
          r_scnt  <= '0;
          r_n     <= n_samples;
          r_busy  <= 1'b1;
          r_conv  <= (n_samples == '0);
        end
        WAIT_S: if (s_if.s_valid) begin
          r_x    <= s_if.s_x;
          r_t    <= s_if.s_t;
          r_acc  <= ACC_W'(r_b);
          r_idx  <= '0;
          r_scnt <= r_scnt + CNT_W'(1);
        end
        MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_idx <= r_idx + IDX_W'(1);
        end
        EVAL: if (w_mismatch && (r_err != '1)) r_err <= r_err + CNT_W'(1);
        UPD: begin
          for (int i = 0; i < NUM_IN; i++) r_w[i] <= w_w_upd[i];
          r_b <= w_b_upd;
        end
        EPOCH_END: begin
          r_epoch <= w_epoch_inc;
          if (r_err == '0) r_conv <= 1'b1;
          else if (w_epoch_inc == EP_W'(MAX_EPOCH)) r_conv <= 1'b0;
          else begin
            r_err  <= '0;
            r_scnt <= '0;
          end
        end
        FIN: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w = '0;
    for (int i = 0; i < NUM_IN; i++) w[i*WW +: WW] = r_w[i];
  end

  assign s_if.s_ready = (r_state == WAIT_S);
  assign b            = r_b;
  assign busy         = r_busy;
  assign done         = r_done;
  assign converged    = r_conv;
  assign epoch_cnt    = r_epoch;
  assign err_cnt      = r_err;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - self-checking bench: vector table, AND training, corners, random vs model
module tb_perceptron_trainer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, s_valid, s_t;
  logic [19:0] n_samples;
  logic [15:0] s_x;
  logic [31:0] w_a;
  logic [15:0] b_a;
  logic [7:0]  w_b, b_b;
  logic        busy_a, done_a, conv_a, busy_b, done_b, conv_b;
  logic [11:0] ep_a, ep_b;
  logic [19:0] err_a, err_b;

  perceptron_trainer_if #(.NUM_IN(2), .XW(8)) ifa ();
  perceptron_trainer_if #(.NUM_IN(1), .XW(8)) ifb ();
  assign ifa.s_valid = s_valid;
  assign ifa.s_x     = s_x;
  assign ifa.s_t     = s_t;
  assign ifb.s_valid = s_valid;
  assign ifb.s_x     = s_x[7:0];
  assign ifb.s_t     = s_t;

  perceptron_trainer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .n_samples(n_samples), .s_if(ifa),
    .w(w_a), .b(b_a), .busy(busy_a), .done(done_a), .converged(conv_a),
    .epoch_cnt(ep_a), .err_cnt(err_a));

  perceptron_trainer #(.NUM_IN(1), .XW(8), .WW(8), .LR_SHIFT(1), .MAX_EPOCH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .n_samples(n_samples), .s_if(ifb),
    .w(w_b), .b(b_b), .busy(busy_b), .done(done_b), .converged(conv_b),
    .epoch_cnt(ep_b), .err_cnt(err_b));

  int checks = 0, errors = 0;
  int ds_x [16][2];
  int ds_t [16];
  int m_w [2];
  int m_b, m_ep, m_err, m_conv;
  int m_ep_errs [$];
  int mon_errs_a [$];
  int mon_errs_b [$];
  int prev_ep_a = 0, prev_err_a = 0, prev_ep_b = 0, prev_err_b = 0;
  int first_w_b = 0, first_b_b = 0;
  int accepted = 0, ready_viol = 0;

  // per-epoch error counts are read in the cycle before epoch_cnt advances
  always @(negedge clk) begin
    if (int'(ep_a) == prev_ep_a + 1) mon_errs_a.push_back(prev_err_a);
    if (int'(ep_b) == prev_ep_b + 1) mon_errs_b.push_back(prev_err_b);
    if (int'(ep_b) == 1 && prev_ep_b == 0) begin
      first_w_b <= $signed(w_b);
      first_b_b <= $signed(b_b);
    end
    if ((ifa.s_ready && !busy_a) || (ifb.s_ready && !busy_b)) ready_viol <= ready_viol + 1;
    prev_ep_a  <= int'(ep_a);
    prev_err_a <= int'(err_a);
    prev_ep_b  <= int'(ep_b);
    prev_err_b <= int'(err_b);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit o_done(input int wh);  return (wh == 0) ? done_a : done_b;           endfunction
  function automatic bit o_ready(input int wh); return (wh == 0) ? ifa.s_ready : ifb.s_ready; endfunction
  function automatic bit o_busy(input int wh);  return (wh == 0) ? busy_a : busy_b;           endfunction
  function automatic bit o_conv(input int wh);  return (wh == 0) ? conv_a : conv_b;           endfunction
  function automatic int o_ep(input int wh);    return (wh == 0) ? int'(ep_a) : int'(ep_b);   endfunction
  function automatic int o_err(input int wh);   return (wh == 0) ? int'(err_a) : int'(err_b); endfunction
  function automatic int o_w(input int wh, input int i);
    if (wh == 0) return $signed(w_a[i*16 +: 16]);
    return $signed(w_b);
  endfunction
  function automatic int o_b(input int wh);
    if (wh == 0) return $signed(b_a);
    return $signed(b_b);
  endfunction

  function automatic int reduce(input longint v, input int ww);
    longint lim = longint'(1) <<< (ww - 1);
`ifdef PERCEPTRON_WEIGHT_SAT_EN
    if (v > lim - 1) return int'(lim - 1);
    if (v < -lim) return int'(-lim);
    return int'(v);
`else
    longint m = v & ((lim <<< 1) - 1);
    if (m >= lim) m = m - (lim <<< 1);
    return int'(m);
`endif
  endfunction

  // Plain perceptron rule over whole epochs
  task automatic model(input int nin, input int ww, input int lr, input int maxep, input int n);
    longint acc;
    int errs;
    m_w[0] = 0; m_w[1] = 0; m_b = 0; m_ep = 0; m_conv = 0; m_err = 0;
    m_ep_errs.delete();
    while (1) begin
      errs = 0;
      for (int s = 0; s < n; s++) begin
        acc = m_b;
        for (int i = 0; i < nin; i++) acc += longint'(ds_x[s][i]) * m_w[i];
        if (((acc >= 0) ? 1 : -1) != ds_t[s]) begin
          errs++;
          for (int i = 0; i < nin; i++)
            m_w[i] = reduce(longint'(m_w[i]) + ds_t[s] * (ds_x[s][i] <<< lr), ww);
          m_b = reduce(longint'(m_b) + ds_t[s] * (1 <<< lr), ww);
        end
      end
      m_ep++;
      m_ep_errs.push_back(errs);
      m_err = errs;
      if (errs == 0) begin m_conv = 1; break; end
      if (m_ep == maxep) break;
    end
  endtask

  task automatic cmp_model(input int wh, input int nin, input int n, input string tag);
    int q [$];
    if (wh == 0) q = mon_errs_a; else q = mon_errs_b;
    for (int i = 0; i < nin; i++) check($sformatf("%s_w%0d", tag, i), o_w(wh, i), m_w[i]);
    check({tag, "_b"}, o_b(wh), m_b);
    check({tag, "_epoch"}, o_ep(wh), m_ep);
    check({tag, "_err"}, o_err(wh), m_err);
    check({tag, "_conv"}, int'(o_conv(wh)), m_conv);
    check({tag, "_nepochs"}, q.size(), m_ep_errs.size());
    for (int e = 0; e < m_ep_errs.size(); e++)
      check($sformatf("%s_ep%0d_errs", tag, e), (e < q.size()) ? q[e] : -1, m_ep_errs[e]);
    check({tag, "_accepted"}, accepted, n * m_ep);
  endtask

  task automatic check_zero(input int wh, input string tag);
    check({tag, "_w0"}, o_w(wh, 0), 0);
    check({tag, "_w1"}, o_w(wh, wh == 0 ? 1 : 0), 0);
    check({tag, "_b"}, o_b(wh), 0);
    check({tag, "_epoch"}, o_ep(wh), 0);
    check({tag, "_err"}, o_err(wh), 0);
    check({tag, "_busy"}, int'(o_busy(wh)), 0);
    check({tag, "_done"}, int'(o_done(wh)), 0);
    check({tag, "_conv"}, int'(o_conv(wh)), 0);
    check({tag, "_ready"}, int'(o_ready(wh)), 0);
  endtask

  // status: 0 = cycle budget expired, 1 = done seen, 2 = aborted by reset
  task automatic run(input int wh, input int n, input bit gaps, input bit poke,
                     input int abort_ep, output int status);
    int  k = 0;
    int  cyc = 0;
    bit  abort = 1'b0;
    status = 0;
    accepted = 0;
    mon_errs_a.delete();
    mon_errs_b.delete();
    @(negedge clk);
    n_samples = 20'(n);
    if (wh == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    while (cyc < 20000) begin
      if (abort) begin
        rst = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        check_zero(wh, "rst_mid");
        rst = 1'b0;
        status = 2;
        return;
      end
      if (o_done(wh)) begin status = 1; break; end
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_x     = {8'(ds_x[k][1]), 8'(ds_x[k][0])};
      s_t     = (ds_t[k] > 0);
      if (poke && cyc == 3) begin
        n_samples = '0;
        if (wh == 0) start_a = 1'b1; else start_b = 1'b1;
      end
      if (s_valid && o_ready(wh)) begin
        accepted++;
        if (o_ep(wh) == abort_ep) abort = 1'b1;
        k = (k + 1) % n;
      end
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      cyc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic load_and();
    ds_x[0] = '{1, 1};   ds_t[0] = 1;
    ds_x[1] = '{1, -1};  ds_t[1] = -1;
    ds_x[2] = '{-1, 1};  ds_t[2] = -1;
    ds_x[3] = '{-1, -1}; ds_t[3] = -1;
  endtask

  task automatic check_and(input string tag);
    check({tag, "_w0"}, o_w(0, 0), 1);
    check({tag, "_w1"}, o_w(0, 1), 1);
    check({tag, "_b"}, o_b(0), -1);
    check({tag, "_epoch"}, o_ep(0), 3);
    check({tag, "_conv"}, int'(conv_a), 1);
    check({tag, "_busy"}, int'(busy_a), 0);
    check({tag, "_nepochs"}, mon_errs_a.size(), 3);
    for (int e = 0; e < 3; e++)
      check($sformatf("%s_ep%0d_errs", tag, e), (e < mon_errs_a.size()) ? mon_errs_a[e] : -1, 2 - e);
    check({tag, "_accepted"}, accepted, 12);
  endtask

  typedef struct { int x0; int x1; int t; int w0; int w1; int b; int ep; } vec_t;
  vec_t tbl [5];

  initial begin
    int st, cyc, sat_exp, n;
    bit nodone;
    tbl[0] = '{1, 1, 1, 0, 0, 0, 1};
    tbl[1] = '{3, -2, -1, -3, 2, -1, 2};
    tbl[2] = '{0, 0, -1, 0, 0, -1, 2};
    tbl[3] = '{-128, 127, -1, 128, -127, -1, 2};
    tbl[4] = '{-7, 4, 1, 0, 0, 0, 1};
`ifdef PERCEPTRON_WEIGHT_SAT_EN
    sat_exp = -128;
`else
    sat_exp = 56;
`endif
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; n_samples = '0;
    s_valid = 1'b0; s_x = '0; s_t = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(0, "reset_a");
    check_zero(1, "reset_b");
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      ds_x[0] = '{tbl[v].x0, tbl[v].x1};
      ds_t[0] = tbl[v].t;
      run(0, 1, 1'b0, 1'b0, -1, st);
      check($sformatf("vec%0d_done", v), st, 1);
      check($sformatf("vec%0d_w0", v), o_w(0, 0), tbl[v].w0);
      check($sformatf("vec%0d_w1", v), o_w(0, 1), tbl[v].w1);
      check($sformatf("vec%0d_b", v), o_b(0), tbl[v].b);
      check($sformatf("vec%0d_epoch", v), o_ep(0), tbl[v].ep);
      check($sformatf("vec%0d_conv", v), int'(conv_a), 1);
      check($sformatf("vec%0d_err", v), o_err(0), 0);
    end

    load_and();
    run(0, 4, 1'b0, 1'b0, -1, st);
    check("and_done", st, 1);
    check_and("and");
    model(2, 16, 0, 1000, 4);
    cmp_model(0, 2, 4, "and_model");

    run(0, 4, 1'b1, 1'b1, -1, st);
    check("and_gaps_done", st, 1);
    check_and("and_gaps");

    @(negedge clk);
    n_samples = '0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; cyc = 1;
    while (!done_a && cyc < 10) begin @(negedge clk); cyc++; end
    check("zero_latency", cyc, 2);
    check("zero_conv", int'(conv_a), 1);
    check("zero_epoch", o_ep(0), 0);
    check("zero_busy", int'(busy_a), 0);

    ds_x[0] = '{100, 0}; ds_t[0] = -1;
    run(1, 1, 1'b0, 1'b0, -1, st);
    check("sat_done", st, 1);
    check("sat_first_w", first_w_b, sat_exp);
    check("sat_first_b", first_b_b, -2);
    model(1, 8, 1, 4, 1);
    cmp_model(1, 1, 1, "sat_model");

    ds_x[0] = '{1, 0}; ds_t[0] = 1;
    ds_x[1] = '{1, 0}; ds_t[1] = -1;
    run(1, 2, 1'b0, 1'b0, -1, st);
    check("nc_done", st, 1);
    check("nc_conv", int'(conv_b), 0);
    check("nc_epoch", o_ep(1), 4);
    check("nc_err_pos", int'(o_err(1) > 0), 1);
    model(1, 8, 1, 4, 2);
    cmp_model(1, 1, 2, "nc_model");

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 8);
      for (int s = 0; s < n; s++) begin
        ds_x[s] = '{int'($urandom_range(0, 255)) - 128, 0};
        ds_t[s] = ($urandom_range(0, 1) != 0) ? 1 : -1;
      end
      run(1, n, r[0], 1'b0, -1, st);
      check($sformatf("rnd%0d_done", r), st, 1);
      model(1, 8, 1, 4, n);
      cmp_model(1, 1, n, $sformatf("rnd%0d", r));
    end

    load_and();
    run(0, 4, 1'b0, 1'b0, 1, st);
    check("rst_mid_aborted", st, 2);
    nodone = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done_a || busy_a) nodone = 1'b0;
    end
    check("rst_mid_no_done", int'(nodone), 1);
    run(0, 4, 1'b0, 1'b0, -1, st);
    check("after_rst_done", st, 1);
    check_and("after_rst");

    check("ready_only_when_busy", ready_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
